// File: rtl/boundary_inject_pkg.sv
// Shared definitions for the boundary injector: flit layout and FSM encodings.
package boundary_inject_pkg;

  localparam int unsigned FLIT_W  = 144;
  localparam int unsigned VLD_BIT = 143;

  // Ring / boundary flit: MSB is the valid bit, the rest is opaque payload.
  typedef struct packed {
    logic              vld;
    logic [VLD_BIT-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_STARVE = 2'd2
  } inj_state_e;

endpackage

// File: rtl/boundary_fifo.sv
// Boundary FIFO: holds flits from the clock boundary until a free ring slot.
// Ports: clk, rst (async active-low), push/push_data write, pop read,
//        head = oldest entry, count = occupancy.
module boundary_fifo
  import boundary_inject_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  flit_t                  push_data,
  input  logic                   pop,
  output flit_t                  head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  flit_t             mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Pointer / occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/boundary_inject.sv
// Boundary injector: merges flits from a clock-boundary output into free
// slots of a local ring, buffering in a small FIFO and requesting upstream
// throttling when buffered flits are starved of slots.
// Ports: clk, rst (async active-low); bnd_ci in / bnd_stall backpressure;
//        ring_ci in / ring_co registered out; thr_req throttle request;
//        ovf sticky overflow; count FIFO occupancy.
module boundary_inject
  import boundary_inject_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  flit_t                  bnd_ci,
  output logic                   bnd_stall,
  input  flit_t                  ring_ci,
  output flit_t                  ring_co,
  output logic                   thr_req,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned BLK_W = $clog2(STARVE_LIM + 1);

  flit_t             head;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              fifo_empty, fifo_full;
  logic              pop, push, bypass, drop;

  flit_t             ring_co_q, ring_co_d;
  inj_state_e        state_q, state_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              ovf_q, ovf_d;
  logic              thr_req_q, thr_req_d;

  boundary_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bnd_ci),
    .pop       (pop),
    .head      (head),
    .count     (fifo_cnt)
  );

  // Slot arbitration: ring traffic first, then FIFO head, then bypass.
  always_comb begin
    fifo_empty = (fifo_cnt == '0);
    fifo_full  = (fifo_cnt == CNT_W'(DEPTH));
    pop        = !ring_ci.vld && !fifo_empty;
    bypass     = !ring_ci.vld && fifo_empty && bnd_ci.vld;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push       = bnd_ci.vld && !bypass && (!fifo_full || pop);
    drop       = bnd_ci.vld && !bypass && fifo_full && !pop;

    ring_co_d = '0;
    if (ring_ci.vld)  ring_co_d = ring_ci;
    else if (pop)     ring_co_d = head;
    else if (bypass)  ring_co_d = bnd_ci;

    cnt_nxt = fifo_cnt;
    if (push && !pop)      cnt_nxt = fifo_cnt + CNT_W'(1);
    else if (pop && !push) cnt_nxt = fifo_cnt - CNT_W'(1);
  end

  // One entry of skid is reserved for the flit already in flight.
  assign bnd_stall = (fifo_cnt >= CNT_W'(DEPTH - 1));

  // Starvation FSM and blocked-cycle counter.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    ovf_d   = ovf_q | drop;

    if (pop) begin
      blk_d = '0;
    end else if (!fifo_empty && ring_ci.vld && (blk_q != BLK_W'(STARVE_LIM))) begin
      blk_d = blk_q + BLK_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (push) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (cnt_nxt == '0)                       state_d = ST_IDLE;
        else if (blk_d == BLK_W'(STARVE_LIM))    state_d = ST_STARVE;
      end
      ST_STARVE: begin
        if (cnt_nxt == '0) state_d = ST_IDLE;
        else if (pop)      state_d = ST_PEND;
      end
      default: state_d = ST_IDLE;
    endcase

    thr_req_d = (state_d == ST_STARVE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ring_co_q <= '0;
      state_q   <= ST_IDLE;
      blk_q     <= '0;
      ovf_q     <= 1'b0;
      thr_req_q <= 1'b0;
    end else begin
      ring_co_q <= ring_co_d;
      state_q   <= state_d;
      blk_q     <= blk_d;
      ovf_q     <= ovf_d;
      thr_req_q <= thr_req_d;
    end
  end

  assign ring_co = ring_co_q;
  assign thr_req = thr_req_q;
  assign ovf     = ovf_q;
  assign count   = fifo_cnt;

endmodule
